// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the horizontal R-nibble edge filter: raster read, 2-stage compare, edge-map write.
// Optional feature macro: SOBEL_EDGE_COUNT_EN adds the edge_count output (white pixels in the current/last frame).
module sobel_frame_ctrl #(
   parameter int H_RES  = 640,
   parameter int V_RES  = 480,
   parameter int ADDR_W = 19,
   parameter int PIX_W  = 24,
   parameter int THR_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [THR_W-1:0]  threshold,
   input  logic              hold,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [PIX_W-1:0]  rd_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [PIX_W-1:0]  wr_data,
   output logic              busy,
   output logic              done
`ifdef SOBEL_EDGE_COUNT_EN
   ,
   output logic [ADDR_W:0]   edge_count
`endif
);

   localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(H_RES - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_RES * V_RES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t            state_reg;
   logic [COL_W-1:0]  col_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [THR_W-1:0]  thr_lat_reg;
   logic              rd_col0_reg;
   logic              s1_valid_reg;
   logic              s1_col0_reg;
   logic [ADDR_W-1:0] s1_addr_reg;
   logic [3:0]        prev_reg;

   logic              issue_go;
   logic [COL_W-1:0]  base_col;
   logic [ADDR_W-1:0] base_addr;
   logic [3:0]        cur_nib;
   logic [3:0]        ref_nib;
   logic [3:0]        diff;
   logic              is_edge;
   logic              unused_bits;

   assign unused_bits = ^rd_data[PIX_W-5:0];

   // The first read is issued on the same edge that accepts start, so IDLE scans from address 0.
   always_comb begin
      issue_go  = !hold && ((state_reg == IDLE && start) || state_reg == RUN);
      base_col  = (state_reg == RUN) ? col_reg  : '0;
      base_addr = (state_reg == RUN) ? addr_reg : '0;
      cur_nib   = rd_data[PIX_W-1 -: 4];
      ref_nib   = s1_col0_reg ? cur_nib : prev_reg;
      diff      = (cur_nib >= ref_nib) ? (cur_nib - ref_nib) : (ref_nib - cur_nib);
      is_edge   = (int'(diff) >= int'(thr_lat_reg));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         col_reg      <= '0;
         addr_reg     <= '0;
         thr_lat_reg  <= '0;
         rd_col0_reg  <= 1'b0;
         s1_valid_reg <= 1'b0;
         s1_col0_reg  <= 1'b0;
         s1_addr_reg  <= '0;
         prev_reg     <= '0;
         rd_en        <= 1'b0;
         rd_addr      <= '0;
         wr_en        <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         if (issue_go) begin
            rd_en       <= 1'b1;
            rd_addr     <= base_addr;
            rd_col0_reg <= (base_col == '0);
            col_reg     <= (base_col == COL_LAST) ? '0 : base_col + COL_W'(1);
            addr_reg    <= base_addr + ADDR_W'(1);
         end else begin
            rd_en <= 1'b0;
            if (state_reg == IDLE) begin
               col_reg  <= '0;
               addr_reg <= '0;
            end
         end

         // Valid/column-0 flags ride alongside each pixel; hold bubbles never touch prev.
         s1_valid_reg <= rd_en;
         s1_addr_reg  <= rd_addr;
         s1_col0_reg  <= rd_col0_reg;
         wr_en        <= s1_valid_reg;
         wr_addr      <= s1_addr_reg;
         wr_data      <= (s1_valid_reg && is_edge) ? '1 : '0;
         if (s1_valid_reg)
            prev_reg <= cur_nib;

         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg   <= RUN;
                  busy        <= 1'b1;
                  thr_lat_reg <= threshold;
               end
            end
            RUN: begin
               if (issue_go && base_addr == ADDR_LAST)
                  state_reg <= DRAIN;
            end
            DRAIN: begin
               // Last pixel is in S2 (being written) once S0/S1 are empty.
               if (!rd_en && !s1_valid_reg) begin
                  state_reg <= DONE;
                  done      <= 1'b1;
               end
            end
            DONE: begin
               state_reg <= IDLE;
               done      <= 1'b0;
               busy      <= 1'b0;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef SOBEL_EDGE_COUNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         edge_count <= '0;
      else if (state_reg == IDLE && start)
         edge_count <= '0;
      else if (s1_valid_reg && is_edge && edge_count != '1)
         edge_count <= edge_count + (ADDR_W+1)'(1);
   end
`endif

endmodule
